mem_access_ctrl: RTL and testbench

Load/store sequencer in front of the data-memory SRAM wrapper (word-addressed, byte-enabled, synchronous read).
- Accepts one byte-addressed load/store request at a time from the MEM stage.
- Converts it to word addresses and byte-lane enables.
- Splits word-crossing (misaligned) accesses into two word accesses.
- Assembles and sign/zero-extends load data.
- Returns a single response pulse.

---
 rtl/mem_access_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-addressed load/store sequencer for a word-addressed,
// byte-enabled synchronous-read SRAM; splits word-crossing accesses in two.
`default_nettype none

module mem_access_ctrl #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_split,
    output logic              mem_cs,
    output logic              mem_re,
    output logic [XLEN-3:0]   mem_raddr,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              mem_we,
    output logic [3:0]        mem_byte_we,
    output logic [XLEN-3:0]   mem_waddr,
    output logic [XLEN-1:0]   mem_wdata
);

    localparam int WAW = XLEN - 2;
    localparam int SHW = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        RD_FIN = 3'd3,
        WR_LO  = 3'd4,
        WR_HI  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t            state;
    logic [WAW-1:0]    wa_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              split_q;
    logic [3:0]        mask_hi_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   lo_word;

    // Request decode, evaluated against the live request in IDLE.
    logic [1:0]        req_off;
    logic [7:0]        req_base;
    logic [7:0]        req_mask;
    logic              req_split;

    assign req_off = req_addr[1:0];

    always_comb begin
        req_base = 8'h0F;
        case (req_size)
            2'b00:   req_base = 8'h01;
            2'b01:   req_base = 8'h03;
            default: req_base = 8'h0F;
        endcase
    end

    assign req_mask  = req_base << req_off;
    assign req_split = (req_size[1] && (req_off != 2'b00)) ||
                       ((req_size == 2'b01) && (req_off == 2'b11));

    // Upper part of a split store: the bytes that spilled past the first word.
    logic [SHW-1:0]    hi_shift;
    logic [XLEN-1:0]   hi_wdata;

    assign hi_shift = SHW'(XLEN) - SHW'({off_q, 3'b000});
    assign hi_wdata = wdata_q >> hi_shift;

    // Load assembly: {hi,lo} pair shifted down by the byte offset.
    logic [2*XLEN-1:0] pair;
    logic [XLEN-1:0]   aligned;
    logic [XLEN-1:0]   load_result;

    assign pair    = split_q ? {mem_rdata, lo_word} : {{XLEN{1'b0}}, mem_rdata};
    assign aligned = XLEN'(pair >> {off_q, 3'b000});

    always_comb begin
        load_result = aligned;
        case (size_q)
            2'b00: load_result = uns_q ? {{(XLEN-8){1'b0}}, aligned[7:0]}
                                       : {{(XLEN-8){aligned[7]}}, aligned[7:0]};
            2'b01: load_result = uns_q ? {{(XLEN-16){1'b0}}, aligned[15:0]}
                                       : {{(XLEN-16){aligned[15]}}, aligned[15:0]};
            default: load_result = aligned;
        endcase
    end

    assign mem_cs = mem_re | mem_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_split  <= 1'b0;
            mem_re      <= 1'b0;
            mem_raddr   <= '0;
            mem_we      <= 1'b0;
            mem_byte_we <= 4'b0000;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            wa_q        <= '0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            mask_hi_q   <= 4'b0000;
            wdata_q     <= '0;
            lo_word     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        wa_q      <= req_addr[XLEN-1:2];
                        off_q     <= req_off;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        split_q   <= req_split;
                        mask_hi_q <= req_mask[7:4];
                        wdata_q   <= req_wdata;
                        if (req_we) begin
                            state       <= WR_LO;
                            mem_we      <= 1'b1;
                            mem_waddr   <= req_addr[XLEN-1:2];
                            mem_byte_we <= req_mask[3:0];
                            mem_wdata   <= req_wdata << {req_off, 3'b000};
                        end else begin
                            state     <= RD_LO;
                            mem_re    <= 1'b1;
                            mem_raddr <= req_addr[XLEN-1:2];
                        end
                    end
                end
                RD_LO: begin
                    if (split_q) begin
                        state     <= RD_HI;
                        mem_raddr <= wa_q + WAW'(1);
                    end else begin
                        state  <= RD_FIN;
                        mem_re <= 1'b0;
                    end
                end
                RD_HI: begin
                    // Data for the low word arrives during this state.
                    lo_word <= mem_rdata;
                    mem_re  <= 1'b0;
                    state   <= RD_FIN;
                end
                RD_FIN: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_result;
                    resp_split <= split_q;
                    state      <= DONE;
                end
                WR_LO: begin
                    if (split_q) begin
                        state       <= WR_HI;
                        mem_waddr   <= wa_q + WAW'(1);
                        mem_byte_we <= mask_hi_q;
                        mem_wdata   <= hi_wdata;
                    end else begin
                        state       <= DONE;
                        mem_we      <= 1'b0;
                        mem_byte_we <= 4'b0000;
                        resp_valid  <= 1'b1;
                        resp_rdata  <= '0;
                        resp_split  <= 1'b0;
                    end
                end
                WR_HI: begin
                    state       <= DONE;
                    mem_we      <= 1'b0;
                    mem_byte_we <= 4'b0000;
                    resp_valid  <= 1'b1;
                    resp_rdata  <= '0;
                    resp_split  <= 1'b1;
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    mem_re      <= 1'b0;
                    mem_we      <= 1'b0;
                    mem_byte_we <= 4'b0000;
                    resp_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: self-checking bench with an SRAM model, a response
// scoreboard, a vector table and hand-written split/wrap/reset sequences.
`default_nettype none

module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_split;
    logic        mem_cs;
    logic        mem_re;
    logic [29:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [3:0]  mem_byte_we;
    logic [29:0] mem_waddr;
    logic [31:0] mem_wdata;

    mem_access_ctrl #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_split   (resp_split),
        .mem_cs       (mem_cs),
        .mem_re       (mem_re),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .mem_we       (mem_we),
        .mem_byte_we  (mem_byte_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_split;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        split;
        int          lat;
        int          k;
    } exp_t;

    typedef struct {
        logic [29:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        int          cyc;
    } log_t;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    viol     = 0;
    int    last_k   = 0;
    exp_t  sb[$];
    log_t  rlog[$];
    log_t  wlog[$];
    vec_t  vecs[$];
    logic [31:0] mem_model [logic [29:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [29:0] a);
        return mem_model.exists(a) ? mem_model[a] : 32'h0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: synchronous read, byte-lane write, plus access logs.
    always @(posedge clk) begin
        logic [31:0] w;
        if ((mem_re && mem_we) || (mem_cs !== (mem_re | mem_we))) viol++;
        if (mem_re) begin
            mem_rdata <= rd_mem(mem_raddr);
            rlog.push_back('{a: mem_raddr, be: 4'b0000, d: 32'h0, cyc: cyc});
        end
        if (mem_we) begin
            w = rd_mem(mem_waddr);
            for (int b = 0; b < 4; b++)
                if (mem_byte_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_model[mem_waddr] = w;
            wlog.push_back('{a: mem_waddr, be: mem_byte_we, d: mem_wdata, cyc: cyc});
        end
    end

    // Scoreboard: each response pulse pops one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rdata", resp_rdata, e.rdata);
                chk("split", {31'd0, resp_split}, {31'd0, e.split});
                chk("latency", cyc - e.k, e.lat);
            end
        end
    end

    task automatic issue(input vec_t v);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        last_k       = cyc;
        sb.push_back('{rdata: v.exp_rdata, split: v.exp_split, lat: v.exp_lat, k: cyc});
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            chk("resp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        mem_model[30'h40]       = 32'hDEADBEEF;
        mem_model[30'h80]       = 32'h80112233;
        mem_model[30'h3FFFFFFF] = 32'hAABBCCDD;
        mem_model[30'h0]        = 32'h11223344;

        // Table: {we,size,uns,addr,wdata, exp_rdata,exp_split,exp_lat}
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h203, 32'h0,        32'hFFFFFF80, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h203, 32'h0,        32'h00000080, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h202, 32'h0,        32'hFFFF8011, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h200, 32'h0,        32'h00002233, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h401, 32'h0,        32'h11223344, 1'b1, 4});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h303, 32'h0,        32'hFFFFA55A, 1'b1, 4});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h601, 32'hFFFFFF7F, 32'h0,        1'b0, 2});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h601, 32'h0,        32'h0000007F, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h600, 32'h0,        32'h00007F00, 1'b0, 3});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h700, 32'h12345678, 32'h0,        1'b0, 2});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 32'h700, 32'h0,        32'h12345678, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b11, 1'b1, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h702, 32'h0,        32'h00001234, 1'b0, 3});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        // Aligned LW: read issued the cycle after accept at word 0x40
        rlog.delete();
        issue('{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3});
        chk("lw_rd_count", rlog.size(), 32'd1);
        if (rlog.size() >= 1) begin
            chk("lw_raddr", {2'b00, rlog[0].a}, 32'h40);
            chk("lw_re_cycle", rlog[0].cyc - last_k, 32'd1);
        end

        // Split SH 0xA55A at 0x303
        wlog.delete();
        issue('{1'b1, 2'b01, 1'b0, 32'h303, 32'h0000A55A, 32'h0, 1'b1, 3});
        chk("sh_wr_count", wlog.size(), 32'd2);
        if (wlog.size() >= 2) begin
            chk("sh_lo_addr", {2'b00, wlog[0].a}, 32'hC0);
            chk("sh_lo_be", {28'd0, wlog[0].be}, 32'b1000);
            chk("sh_lo_byte", {24'd0, wlog[0].d[31:24]}, 32'h5A);
            chk("sh_hi_addr", {2'b00, wlog[1].a}, 32'hC1);
            chk("sh_hi_be", {28'd0, wlog[1].be}, 32'b0001);
            chk("sh_hi_byte", {24'd0, wlog[1].d[7:0]}, 32'hA5);
        end

        // Split SW 0x11223344 at 0x401
        wlog.delete();
        issue('{1'b1, 2'b10, 1'b0, 32'h401, 32'h11223344, 32'h0, 1'b1, 3});
        chk("sw_wr_count", wlog.size(), 32'd2);
        if (wlog.size() >= 2) begin
            chk("sw_lo_addr", {2'b00, wlog[0].a}, 32'h100);
            chk("sw_lo_be", {28'd0, wlog[0].be}, 32'b1110);
            chk("sw_hi_addr", {2'b00, wlog[1].a}, 32'h101);
            chk("sw_hi_be", {28'd0, wlog[1].be}, 32'b0001);
        end

        for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);

        // Split LW at 0xFFFFFFFE wraps the second word address to 0
        rlog.delete();
        issue('{1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h3344AABB, 1'b1, 4});
        chk("wrap_rd_count", rlog.size(), 32'd2);
        if (rlog.size() >= 2) begin
            chk("wrap_raddr0", {2'b00, rlog[0].a}, 32'h3FFFFFFF);
            chk("wrap_raddr1", {2'b00, rlog[1].a}, 32'h0);
        end

        // Reset during WR_HI of a split store (SW 0xCAFEBABE at 0x502)
        mem_model[30'h140] = 32'h11111111;
        mem_model[30'h141] = 32'h22222222;
        wlog.delete();
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h502; req_wdata = 32'hCAFEBABE; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("whi_be_before_rst", {28'd0, mem_byte_we}, 32'b0011);
        rst_n = 1'b0;
        #1;
        chk("rst_async_we", {31'd0, mem_we}, 32'd0);
        chk("rst_async_be", {28'd0, mem_byte_we}, 32'd0);
        chk("rst_async_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", {31'd0, req_ready}, 32'd1);
        chk("rst_lo_word", rd_mem(30'h140), 32'hBABE1111);
        chk("rst_hi_word", rd_mem(30'h141), 32'h22222222);
        chk("rst_wr_count", wlog.size(), 32'd1);

        repeat (4) @(negedge clk);
        chk("sram_ctrl_viol", viol, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
